// File: rtl/product_bcd_pkg.sv
// Shared constants and FSM state type for the multiplier-to-display datapath.
package product_bcd_pkg;

  localparam int unsigned PROD_W     = 10;
  localparam int unsigned BCD_DIGITS = 4;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } conv_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/product_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with
// valid/ready handshakes on both sides.
module product_bcd_conv
  import product_bcd_pkg::*;
#(
  parameter int unsigned IN_W   = PROD_W,
  parameter int unsigned DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned AccW = 4 * DIGITS;
  localparam int unsigned CntW = (IN_W > 1) ? $clog2(IN_W) : 1;

  conv_state_e           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IN_W-1:0]       bin_q, bin_d;
  logic [AccW-1:0]       acc_q, acc_d;
  logic [AccW-1:0]       bcd_q, bcd_d;
  logic                  out_valid_q, out_valid_d;

  logic [AccW-1:0]       acc_adj;
  logic [AccW-1:0]       acc_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  // The top accumulator bit is always zero when 10^DIGITS > 2^IN_W - 1, so truncation is safe.
  assign acc_shift = AccW'({acc_adj, bin_q[IN_W-1]});

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    bcd_d       = bcd_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          bin_d   = product;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        acc_d = acc_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(IN_W - 1)) begin
          bcd_d       = acc_shift;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bin_q       <= '0;
      acc_q       <= '0;
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      bcd_q       <= bcd_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_product_bcd_conv.sv
// Directed bench for product_bcd_conv: hand-computed BCD results, latency and handshakes.
module tb_product_bcd_conv;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  product;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] bcd;

  int total = 0;
  int bad   = 0;

  product_bcd_conv #(
    .IN_W   (10),
    .DIGITS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  // Accept one product, wait for the result, check it, then take it.
  task automatic run_one(input logic [9:0] val, input logic [15:0] exp, input string tag);
    int n;
    product  = val;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    wait_out(n);
    check({tag, "_latency"}, 32'(n), 32'd10);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy_again"}, 32'(in_ready), 32'd1);
    check({tag, "_bcd_hold"}, 32'(bcd), 32'(exp));
  endtask

  logic [9:0]  b2b_in  [5];
  logic [15:0] b2b_exp [5];

  initial begin
    int n;
    logic [15:0] held;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    product   = '0;
    tick();
    tick();
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_rdy_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_rel_rdy", 32'(in_ready), 32'd1);

    run_one(10'd0,    16'h0000, "p0");
    run_one(10'd225,  16'h0225, "p225");
    run_one(10'd1023, 16'h1023, "p1023");
    run_one(10'd999,  16'h0999, "p999");

    // Backpressure: hold the result for 20 cycles.
    product  = 10'd42;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    check("bp_latency", 32'(n), 32'd10);
    check("bp_bcd", 32'(bcd), 32'h0042);
    held = bcd;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_bcd_stable", 32'(bcd), 32'(held));
      check("bp_ov_held", 32'(out_valid), 32'd1);
      check("bp_rdy_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_rdy_after", 32'(in_ready), 32'd1);
    check("bp_ov_after", 32'(out_valid), 32'd0);

    // in_valid held with 500 during conversion of 37.
    product  = 10'd37;
    in_valid = 1'b1;
    tick();
    product  = 10'd500;
    wait_out(n);
    check("hold_latency", 32'(n), 32'd10);
    check("hold_bcd37", 32'(bcd), 32'h0037);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_idle_rdy", 32'(in_ready), 32'd1);
    check("hold_ov_clr", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("hold_500_taken", 32'(in_ready), 32'd0);
    wait_out(n);
    check("hold_500_latency", 32'(n), 32'd10);
    check("hold_bcd500", 32'(bcd), 32'h0500);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a conversion of 768.
    product  = 10'd768;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) tick();
    check("mid_rst_no_result", 32'(out_valid), 32'd0);
    run_one(10'd768, 16'h0768, "p768");

    // Back-to-back with out_ready tied high.
    b2b_in[0] = 10'd1;   b2b_exp[0] = 16'h0001;
    b2b_in[1] = 10'd9;   b2b_exp[1] = 16'h0009;
    b2b_in[2] = 10'd10;  b2b_exp[2] = 16'h0010;
    b2b_in[3] = 10'd99;  b2b_exp[3] = 16'h0099;
    b2b_in[4] = 10'd100; b2b_exp[4] = 16'h0100;
    begin
      int idx  = 0;
      int k    = 0;
      int cyc  = 0;
      int last = 0;
      logic acc;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      product   = b2b_in[0];
      while (k < 5 && cyc < 200) begin
        acc = in_valid && in_ready;
        tick();
        cyc++;
        if (acc) begin
          idx++;
          if (idx < 5) product = b2b_in[idx];
          else in_valid = 1'b0;
        end
        if (out_valid === 1'b1) begin
          check("b2b_bcd", 32'(bcd), 32'(b2b_exp[k]));
          if (k > 0) check("b2b_spacing", 32'(cyc - last), 32'd12);
          last = cyc;
          k++;
        end
      end
      check("b2b_count", 32'(k), 32'd5);
      out_ready = 1'b0;
      in_valid  = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
